instr_encode: RTL
=================

// Module: instr_encode
// PURPOSE
//  Packs decoded instruction fields (flag/oper/rega/regb/imm/mem_op/mem_addr) into the
//  30-bit DungV instruction word, the inverse of the decode stage. Sits between the
//  assembler/loader front end and instruction memory. Input and output use a valid/ready
//  handshake, with a DEPTH-entry FIFO between them.
// PARAMETERS
//  DEPTH  4  output FIFO entries; power of 2, >=2
//  CNT_W  8  width of issued-word counter (saturating)
// PORTS
//  clk        in   1   system clock, all logic on posedge
//  rst        in   1   synchronous reset, active-high
//  in_valid   in   1   field bundle valid
//  in_ready   out  1   encoder can accept; = !fifo_full
//  in_flag    in   2   0 NOP, 1 ALU r-r, 2 ALU ext, 3 memory
//  in_oper    in   4   ALU opcode (flags 1,2)
//  in_rega    in   6   register A
//  in_regb    in   6   register B
//  in_imm     in   16  immediate
//  in_mem_op  in   2   memory op (flag 3)
//  in_maddr   in   10  memory address
//  out_valid  out  1   out_instr holds a word; = !fifo_empty
//  out_ready  in   1   consumer takes word when out_valid&&out_ready
//  out_instr  out  30  packed word (FIFO head)
//  issued     out  CNT_W  words popped since reset, saturates at all-ones
//  err        out  1   1-cycle pulse on illegal bundle (CHECK build only)
// BEHAVIOUR
//  Encoding (bit 0 = LSB; every bit not listed is 0):
//   flag0: word = 30'h0 (all fields ignored)
//   flag1: [1:0]=1 [5:2]=oper [11:6]=rega [17:12]=regb
//   flag2,oper2: [1:0]=2 [5:2]=2 [11:6]=rega [17:12]=regb
//   flag2,oper3: [1:0]=2 [5:2]=3 [11:6]=rega [27:12]=imm
//   flag2,other oper: illegal -> word = 30'h0 (NOP)
//   flag3,mem_op 1|2: [1:0]=3 [3:2]=mem_op [9:4]=rega [19:10]=maddr
//   flag3,mem_op 0|3: [1:0]=3 [3:2]=mem_op [13:4]=maddr [29:14]=imm
//  Push on in_valid&&in_ready; packed word written into FIFO that edge.
//  Latency: bundle accepted at edge N -> out_valid=1 and out_instr valid after edge N.
//  Pop on out_valid&&out_ready; rd_ptr advances, issued++ (saturate at 2^CNT_W-1).
//  Simultaneous push+pop: allowed when not full; count unchanged; FIFO never full.
//  Full: in_ready=0, in_valid ignored, no overwrite. No pass-through when full.
//  Empty: out_valid=0, out_instr undefined-for-use (bench must not check it).
//  Pointers log2(DEPTH) bits, wrap modulo DEPTH; occupancy counter 0..DEPTH.
//  FIFO order is strict: words leave in acceptance order.
//  out_instr/out_valid remain stable while out_valid&&!out_ready.
//  Reset (any cycle, including mid-stream): pointers=0, count=0, out_valid=0,
//   in_ready=1 on the following cycle, issued=0, err=0; FIFO contents discarded.
// CONFIGURATION
//  INSTR_ENC_CHECK_EN defined:
//   illegal bundle = flag2 with oper not in {2,3}.
//   On an accepted illegal bundle: nothing is pushed, err=1 for exactly 1 cycle.
//   A legal bundle accepted on the same edge as err deassertion is unaffected.
//  Not defined: illegal bundle is pushed as 30'h0 (NOP) and err is tied 0.
// TESTING
//  1 rst, push flag1 oper5 rega3 regb9 -> next cycle out_valid=1, out_instr=30'h0000_90D5
//  2 push flag2 oper3 rega1 imm16'hBEEF -> out_instr=30'h0BEE_F04E
//  3 flag3 mem_op2 rega7 maddr10'h155 -> 30'h0005_547B; mem_op0 maddr3 imm16'h1234 -> 30'h048D_0033
//  4 hold out_ready=0, push DEPTH+2 bundles -> in_ready=0 after DEPTH pushes; drain returns first DEPTH in order; issued=DEPTH
//  5 flag2 oper7: CHECK build -> err pulse, FIFO stays empty; default -> 30'h0 pushed
//  6 assert rst with 3 words queued -> out_valid=0, issued=0; push 1 -> exactly that word emerges

Source files
------------

// File: rtl/instr_encode.sv
// Packs decoded instruction fields into the 30-bit DungV word and queues it in a small FIFO.
// Define INSTR_ENC_CHECK_EN to drop illegal ALU-ext bundles and flag them on err.
module instr_encode #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_flag,
  input  logic [3:0]       in_oper,
  input  logic [5:0]       in_rega,
  input  logic [5:0]       in_regb,
  input  logic [15:0]      in_imm,
  input  logic [1:0]       in_mem_op,
  input  logic [9:0]       in_maddr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [29:0]      out_instr,
  output logic [CNT_W-1:0] issued,
  output logic             err
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FullCnt = CW'(DEPTH);

  logic [29:0]      mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    count_q, count_d;
  logic [CNT_W-1:0] issued_q;
  logic [29:0]      word;
  logic             full, push, push_en, pop;

  always_comb begin
    word = '0;
    case (in_flag)
      2'd1: word = {12'b0, in_regb, in_rega, in_oper, 2'd1};
      2'd2: begin
        if (in_oper == 4'd2) begin
          word = {12'b0, in_regb, in_rega, 4'd2, 2'd2};
        end else if (in_oper == 4'd3) begin
          word = {2'b0, in_imm, in_rega, 4'd3, 2'd2};
        end else begin
          word = '0;
        end
      end
      2'd3: begin
        if (in_mem_op == 2'd1 || in_mem_op == 2'd2) begin
          word = {10'b0, in_maddr, in_rega, in_mem_op, 2'd3};
        end else begin
          word = {in_imm, in_maddr, in_mem_op, 2'd3};
        end
      end
      default: word = '0;
    endcase
  end

  assign full      = (count_q == FullCnt);
  assign in_ready  = !full;
  assign out_valid = (count_q != '0);
  assign out_instr = mem_q[rd_ptr_q];
  assign issued    = issued_q;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef INSTR_ENC_CHECK_EN
  logic illegal;
  logic err_q;

  assign illegal = (in_flag == 2'd2) && (in_oper != 4'd2) && (in_oper != 4'd3);
  assign push_en = push && !illegal;
  assign err     = err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= push && illegal;
    end
  end
`else
  assign push_en = push;
  assign err     = 1'b0;
`endif

  always_comb begin
    count_d = count_q;
    case ({push_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      issued_q <= '0;
    end else begin
      count_q <= count_d;
      if (push_en) begin
        wr_ptr_q <= (wr_ptr_q == AW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= (rd_ptr_q == AW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        if (issued_q != '1) begin
          issued_q <= issued_q + 1'b1;
        end
      end
    end
  end

  // Storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

endmodule
